// File: rtl/digit_scan_scheduler_if.sv
// Bus bundle between the BCD time registers, the digit scan scheduler and the panel.
// The master side drives scan controls and digits; the slave side returns the panel drive.
interface digit_scan_scheduler_if #(
  parameter int NUM_DIGITS = 6
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blink_tick;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [IW-1:0]           scan_idx;
  logic                    frame_done;

  modport master (
    output enable,
    output digits_bcd,
    output blink_mask,
    output blink_tick,
    input  bcd_out,
    input  digit_en,
    input  scan_idx,
    input  frame_done
  );

  modport slave (
    input  enable,
    input  digits_bcd,
    input  blink_mask,
    input  blink_tick,
    output bcd_out,
    output digit_en,
    output scan_idx,
    output frame_done
  );
endinterface

// File: rtl/digit_scan_scheduler.sv
// Scans NUM_DIGITS BCD digits through one shared decoder with blanking guard and blink.
// Define LEADING_ZERO_BLANK_EN to hide a zero in the most significant digit.
module digit_scan_scheduler #(
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 24000,
  parameter int BLANK_CYCLES = 16
) (
  input logic clk,
  input logic reset_n,
  digit_scan_scheduler_if.slave bus
);

  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES)
                      ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int DW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam state_t FIRST = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

  state_t                state;
  state_t                state_n;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_n;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_n;
  logic [DW-1:0]         snap;
  logic [DW-1:0]         snap_n;
  logic [NUM_DIGITS-1:0] smask;
  logic [NUM_DIGITS-1:0] smask_n;
  logic                  phase;
  logic                  phase_n;
  logic                  load;
  logic                  fd_n;

  logic                  st_idle;
  logic                  st_blank;
  logic                  st_drive;

  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] sel;
  logic [3:0]            bcd_n;
  logic [NUM_DIGITS-1:0] en_n;

  logic [3:0]            bcd_q;
  logic [NUM_DIGITS-1:0] en_q;
  logic [IW-1:0]         idx_q;
  logic                  fd_q;

  assign st_idle  = (state == IDLE);
  assign st_blank = (state == BLANK);
  assign st_drive = (state == DRIVE);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + 1'b1;
    load    = 1'b0;
    fd_n    = 1'b0;
    if (!bus.enable) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          state_n = FIRST;
          idx_n   = '0;
          cnt_n   = '0;
          load    = 1'b1;
        end
        st_blank: begin
          if (cnt == BLANK_LAST) begin
            state_n = DRIVE;
            cnt_n   = '0;
          end
        end
        st_drive: begin
          if (cnt == DWELL_LAST) begin
            state_n = FIRST;
            cnt_n   = '0;
            if (idx == IDX_LAST) begin
              idx_n = '0;
              fd_n  = 1'b1;
              load  = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Snapshot only at frame start so a carry never tears a frame.
  assign snap_n  = load ? bus.digits_bcd : snap;
  assign smask_n = load ? bus.blink_mask : smask;
  assign phase_n = phase ^ bus.blink_tick;

  // Outputs are precomputed from next-state values and then registered.
  always_comb begin
    nib   = '0;
    sel   = '0;
    bcd_n = 4'hF;
    en_n  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_n == IW'(i)) begin
        nib    = snap_n[4*i +: 4];
        sel[i] = 1'b1;
      end
    end
    if (state_n == DRIVE) begin
      bcd_n = nib;
      en_n  = sel;
      if (phase_n && |(sel & smask_n)) begin
        en_n = '0;
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_n == IDX_LAST && nib == 4'd0) begin
        bcd_n = 4'hF;
        en_n  = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      snap  <= '0;
      smask <= '0;
      phase <= 1'b0;
      bcd_q <= 4'hF;
      en_q  <= '0;
      idx_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      snap  <= snap_n;
      smask <= smask_n;
      phase <= phase_n;
      bcd_q <= bcd_n;
      en_q  <= en_n;
      idx_q <= idx_n;
      fd_q  <= fd_n;
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.digit_en   = en_q;
  assign bus.scan_idx   = idx_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_digit_scan_scheduler.sv
// Scoreboard bench for digit_scan_scheduler: expected outputs are queued per cycle
// when stimulus is issued, and a negedge monitor pops and compares them.
module tb_digit_scan_scheduler;

  localparam int ND = 6;
  localparam int DWL = 4;
  localparam int BK = 2;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  digit_scan_scheduler_if #(.NUM_DIGITS(ND)) bus ();

  digit_scan_scheduler #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DWL),
    .BLANK_CYCLES(BK)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] bcd;
    logic [5:0] en;
    logic [2:0] idx;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, logic [3:0] b, logic [5:0] e,
                               logic [2:0] i, logic f, string t);
    exp_t x;
    x.cyc = c;
    x.bcd = b;
    x.en  = e;
    x.idx = i;
    x.fd  = f;
    x.tag = t;
    q.push_back(x);
  endfunction

  function automatic void push_idle(int c, string t);
    push(c, 4'hF, 6'd0, 3'd0, 1'b0, t);
  endfunction

  // One frame: per digit BK blank cycles then DWL drive cycles.
  function automatic void push_frame(int c0, logic [23:0] d, logic [5:0] m,
                                     logic ph, logic fd0, int n, string t);
    int         k;
    logic [3:0] nb;
    logic [3:0] b;
    logic [5:0] e;
    k = 0;
    for (int g = 0; g < ND; g++) begin
      nb = d[4*g +: 4];
      for (int s = 0; s < BK + DWL; s++) begin
        if (k < n) begin
          if (s < BK) begin
            push(c0 + k, 4'hF, 6'd0, 3'(g), (k == 0) ? fd0 : 1'b0, t);
          end else begin
            b = nb;
            e = 6'd1 << g;
            if (ph && m[g]) e = 6'd0;
`ifdef LEADING_ZERO_BLANK_EN
            if (g == ND - 1 && nb == 4'd0) begin
              b = 4'hF;
              e = 6'd0;
            end
`endif
            push(c0 + k, b, e, 3'(g), 1'b0, t);
          end
        end
        k++;
      end
    end
  endfunction

  exp_t mx;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mx = q.pop_front();
      checks++;
      if (mx.cyc < cyc) begin
        $display("FAIL %s cyc=%0d not compared in its cycle", mx.tag, mx.cyc);
      end else if (bus.bcd_out === mx.bcd && bus.digit_en === mx.en &&
                   bus.scan_idx === mx.idx && bus.frame_done === mx.fd) begin
        passed++;
      end else begin
        $display("FAIL %s cyc=%0d got bcd=%h en=%b idx=%0d fd=%b want bcd=%h en=%b idx=%0d fd=%b",
                 mx.tag, cyc, bus.bcd_out, bus.digit_en, bus.scan_idx,
                 bus.frame_done, mx.bcd, mx.en, mx.idx, mx.fd);
      end
    end
  end

  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.enable     = 1'b0;
    bus.digits_bcd = '0;
    bus.blink_mask = '0;
    bus.blink_tick = 1'b0;

    push(2, 4'hF, 6'd0, 3'd0, 1'b0, "reset");
    push(3, 4'hF, 6'd0, 3'd0, 1'b0, "reset");

    wait_cyc(3);
    reset_n = 1'b1;
    push_idle(4, "idle");
    push_idle(5, "idle");

    wait_cyc(5);
    bus.enable     = 1'b1;
    bus.digits_bcd = 24'h235959;
    push_frame(6, 24'h235959, 6'b0, 1'b0, 1'b0, 36, "frame1");

    wait_cyc(19);
    bus.digits_bcd = 24'h000000;
    push_frame(42, 24'h000000, 6'b0, 1'b0, 1'b1, 36, "frame2_snap");

    wait_cyc(60);
    bus.digits_bcd = 24'h235959;
    bus.blink_mask = 6'b000011;
    push_frame(78, 24'h235959, 6'b000011, 1'b1, 1'b1, 36, "frame3_blink");

    wait_cyc(70);
    bus.blink_tick = 1'b1;
    wait_cyc(71);
    bus.blink_tick = 1'b0;

    wait_cyc(100);
    bus.blink_tick = 1'b1;
    wait_cyc(101);
    bus.blink_tick = 1'b0;
    push_frame(114, 24'h235959, 6'b000011, 1'b0, 1'b1, 36, "frame4_unblink");
    push_frame(150, 24'h235959, 6'b000011, 1'b0, 1'b1, 21, "frame5_pre_dis");
    for (int c = 171; c <= 175; c++) push_idle(c, "disable");

    wait_cyc(170);
    bus.enable = 1'b0;

    wait_cyc(175);
    bus.enable = 1'b1;
    push_frame(176, 24'h235959, 6'b000011, 1'b0, 1'b0, 36, "reenable");

    wait_cyc(205);
    bus.blink_tick = 1'b1;
    wait_cyc(206);
    bus.blink_tick = 1'b0;
    push_frame(212, 24'h235959, 6'b000011, 1'b1, 1'b1, 9, "frame7_pre_rst");

    wait_cyc(220);
    reset_n = 1'b0;
    push(221, 4'hF, 6'd0, 3'd0, 1'b0, "midrun_reset");

    wait_cyc(221);
    reset_n = 1'b1;
    push_frame(222, 24'h235959, 6'b000011, 1'b0, 1'b0, 36, "post_reset");

    wait_cyc(230);
    bus.digits_bcd = 24'h091500;
    bus.blink_mask = 6'b000000;
    push_frame(258, 24'h091500, 6'b0, 1'b0, 1'b1, 36, "lead_zero");

    wait_cyc(300);
    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      mx = q.pop_front();
      checks++;
      $display("FAIL %s cyc=%0d never compared", mx.tag, mx.cyc);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
